// File: rtl/combat_round_ctrl.sv
// Fighting-round controller: round sequencing, per-player attack timing,
// single-hit registration per attack, health bookkeeping and winner decision.
module combat_round_ctrl #(
  parameter int unsigned TICK_DIV        = 1666666,
  parameter int unsigned MAX_HEALTH      = 31,
  parameter int unsigned PUNCH_DMG       = 2,
  parameter int unsigned KICK_DMG        = 4,
  parameter int unsigned ACTIVE_TICKS    = 8,
  parameter int unsigned COOLDOWN_TICKS  = 12,
  parameter int unsigned COUNTDOWN_TICKS = 180,
  parameter int unsigned KO_TICKS        = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_punch,
  input  logic       p1_kick,
  input  logic       p1_block,
  input  logic       p2_punch,
  input  logic       p2_kick,
  input  logic       p2_block,
  input  logic       p1_colliding,
  input  logic       p2_colliding,
  output logic [4:0] health_l,
  output logic [4:0] health_r,
  output logic [2:0] p1_char_state,
  output logic [2:0] p2_char_state,
  output logic [1:0] round_state,
  output logic [1:0] winner,
  output logic       game_tick,
  output logic       move_enable
);

  typedef enum logic [1:0] {
    R_IDLE      = 2'b00,
    R_COUNTDOWN = 2'b01,
    R_FIGHT     = 2'b10,
    R_KO        = 2'b11
  } round_t;

  typedef enum logic [1:0] {
    A_READY,
    A_ACTIVE,
    A_COOLDOWN
  } atk_t;

  localparam int unsigned   CW        = $clog2(TICK_DIV);
  localparam int unsigned   TW        = 16;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [4:0]    HP_FULL   = 5'(MAX_HEALTH);

  logic [CW-1:0] tick_cnt;
  logic          tick;

  round_t        rs_q, rs_nx;
  logic [TW-1:0] rt_q, rt_nx;
  logic [1:0]    win_q, win_nx;
  logic [4:0]    hp_q [2];
  logic [4:0]    hp_nx [2];

  atk_t          as_q [2];
  atk_t          as_nx [2];
  logic [TW-1:0] at_q [2];
  logic [TW-1:0] at_nx [2];
  logic          kick_sel_q [2];
  logic          kick_sel_nx [2];
  logic          hit_q [2];
  logic          hit_nx [2];
  logic [2:0]    pose_q [2];
  logic [2:0]    pose_nx [2];

  logic [1:0]    punch_in, kick_in, block_in;
  logic          colliding;
  logic [4:0]    dmg;

  assign punch_in  = {p2_punch, p1_punch};
  assign kick_in   = {p2_kick, p1_kick};
  assign block_in  = {p2_block, p1_block};
  assign colliding = p1_colliding | p2_colliding;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    rs_nx       = rs_q;
    rt_nx       = rt_q;
    win_nx      = win_q;
    hp_nx       = hp_q;
    as_nx       = as_q;
    at_nx       = at_q;
    kick_sel_nx = kick_sel_q;
    hit_nx      = hit_q;
    pose_nx     = pose_q;
    dmg         = '0;

    if (tick) begin
      // Hits resolve before the round FSM so a lethal hit ends the round on the same tick.
      for (int unsigned i = 0; i < 2; i++) begin
        if (rs_q == R_FIGHT && as_q[i[0]] == A_ACTIVE && !hit_q[i[0]] && colliding) begin
          hit_nx[i[0]] = 1'b1;
          dmg = kick_sel_q[i[0]] ? 5'(KICK_DMG) : 5'(PUNCH_DMG);
          if (block_in[~i[0]]) begin
            dmg = dmg >> 1;
          end
          hp_nx[~i[0]] = (hp_q[~i[0]] > dmg) ? hp_q[~i[0]] - dmg : '0;
        end
      end

      case (rs_q)
        R_IDLE: begin
          if (start) begin
            hp_nx  = '{default: HP_FULL};
            win_nx = '0;
            rt_nx  = TW'(COUNTDOWN_TICKS - 1);
            rs_nx  = R_COUNTDOWN;
          end
        end
        R_COUNTDOWN: begin
          if (rt_q == '0) begin
            rs_nx = R_FIGHT;
          end else begin
            rt_nx = rt_q - 1'b1;
          end
        end
        R_FIGHT: begin
          if (hp_nx[0] == '0 || hp_nx[1] == '0) begin
            rs_nx  = R_KO;
            rt_nx  = TW'(KO_TICKS - 1);
            win_nx = {hp_nx[0] == '0, hp_nx[1] == '0};
          end
        end
        R_KO: begin
          if (rt_q == '0) begin
            rs_nx = R_IDLE;
          end else begin
            rt_nx = rt_q - 1'b1;
          end
        end
        default: rs_nx = R_IDLE;
      endcase

      // Attacks only run while the round stays in FIGHT across this tick.
      for (int unsigned i = 0; i < 2; i++) begin
        if (rs_q == R_FIGHT && rs_nx == R_FIGHT) begin
          case (as_q[i[0]])
            A_READY: begin
              if (kick_in[i[0]] || punch_in[i[0]]) begin
                as_nx[i[0]]       = A_ACTIVE;
                kick_sel_nx[i[0]] = kick_in[i[0]];
                at_nx[i[0]]       = TW'(ACTIVE_TICKS - 1);
                hit_nx[i[0]]      = 1'b0;
              end
            end
            A_ACTIVE: begin
              if (at_q[i[0]] == '0) begin
                as_nx[i[0]] = A_COOLDOWN;
                at_nx[i[0]] = TW'(COOLDOWN_TICKS - 1);
              end else begin
                at_nx[i[0]] = at_q[i[0]] - 1'b1;
              end
            end
            A_COOLDOWN: begin
              if (at_q[i[0]] == '0) begin
                as_nx[i[0]] = A_READY;
              end else begin
                at_nx[i[0]] = at_q[i[0]] - 1'b1;
              end
            end
            default: as_nx[i[0]] = A_READY;
          endcase

          if (as_nx[i[0]] == A_ACTIVE) begin
            pose_nx[i[0]] = kick_sel_nx[i[0]] ? 3'b010 : 3'b001;
          end else begin
            pose_nx[i[0]] = block_in[i[0]] ? 3'b100 : 3'b000;
          end
        end else begin
          as_nx[i[0]]   = A_READY;
          pose_nx[i[0]] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_q       <= R_IDLE;
      rt_q       <= '0;
      win_q      <= '0;
      hp_q       <= '{default: HP_FULL};
      as_q       <= '{default: A_READY};
      at_q       <= '{default: '0};
      kick_sel_q <= '{default: 1'b0};
      hit_q      <= '{default: 1'b0};
      pose_q     <= '{default: 3'b000};
    end else begin
      rs_q       <= rs_nx;
      rt_q       <= rt_nx;
      win_q      <= win_nx;
      hp_q       <= hp_nx;
      as_q       <= as_nx;
      at_q       <= at_nx;
      kick_sel_q <= kick_sel_nx;
      hit_q      <= hit_nx;
      pose_q     <= pose_nx;
    end
  end

  assign health_l      = hp_q[0];
  assign health_r      = hp_q[1];
  assign p1_char_state = pose_q[0];
  assign p2_char_state = pose_q[1];
  assign round_state   = rs_q;
  assign winner        = win_q;
  assign game_tick     = tick;
  assign move_enable   = (rs_q == R_FIGHT);

endmodule

// File: tb/tb_combat_round_ctrl.sv
// Randomized bench for combat_round_ctrl against an age-based round/attack model.
module tb_combat_round_ctrl;

  localparam int TD = 4;
  localparam int CD = 2;
  localparam int AT = 2;
  localparam int CT = 2;
  localparam int KT = 2;
  localparam int MH = 31;
  localparam int PD = 2;
  localparam int KD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       p1_punch = 1'b0, p1_kick = 1'b0, p1_block = 1'b0;
  logic       p2_punch = 1'b0, p2_kick = 1'b0, p2_block = 1'b0;
  logic       p1_colliding = 1'b0, p2_colliding = 1'b0;
  logic [4:0] health_l, health_r;
  logic [2:0] p1_char_state, p2_char_state;
  logic [1:0] round_state, winner;
  logic       game_tick, move_enable;

  combat_round_ctrl #(
    .TICK_DIV       (TD),
    .MAX_HEALTH     (MH),
    .PUNCH_DMG      (PD),
    .KICK_DMG       (KD),
    .ACTIVE_TICKS   (AT),
    .COOLDOWN_TICKS (CT),
    .COUNTDOWN_TICKS(CD),
    .KO_TICKS       (KT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .p1_punch     (p1_punch),
    .p1_kick      (p1_kick),
    .p1_block     (p1_block),
    .p2_punch     (p2_punch),
    .p2_kick      (p2_kick),
    .p2_block     (p2_block),
    .p1_colliding (p1_colliding),
    .p2_colliding (p2_colliding),
    .health_l     (health_l),
    .health_r     (health_r),
    .p1_char_state(p1_char_state),
    .p2_char_state(p2_char_state),
    .round_state  (round_state),
    .winner       (winner),
    .game_tick    (game_tick),
    .move_enable  (move_enable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 idle, 1 countdown, 2 fight, 3 ko; attack age -1 = ready.
  int m_cnt, m_phase, m_left, m_win;
  int m_hp [2];
  int m_age [2];
  int m_pose [2];
  bit m_kick [2];
  bit m_hit [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_left = 0; m_win = 0;
    for (int i = 0; i < 2; i++) begin
      m_hp[i] = MH; m_age[i] = -1; m_pose[i] = 0; m_kick[i] = 1'b0; m_hit[i] = 1'b0;
    end
  endtask

  task automatic model_tick();
    bit pu [2];
    bit ki [2];
    bit bl [2];
    bit coll;
    int nh [2];
    int old_phase;
    int d;
    pu = '{p1_punch, p2_punch};
    ki = '{p1_kick, p2_kick};
    bl = '{p1_block, p2_block};
    coll = p1_colliding | p2_colliding;
    old_phase = m_phase;
    nh = m_hp;
    if (old_phase == 2) begin
      for (int i = 0; i < 2; i++) begin
        if (m_age[i] >= 0 && m_age[i] < AT && !m_hit[i] && coll) begin
          m_hit[i] = 1'b1;
          d = m_kick[i] ? KD : PD;
          if (bl[1-i]) d = d / 2;
          nh[1-i] = (nh[1-i] > d) ? nh[1-i] - d : 0;
        end
      end
    end
    case (old_phase)
      0: if (start) begin
        nh = '{MH, MH}; m_win = 0; m_phase = 1; m_left = CD;
      end
      1: begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      2: if (nh[0] == 0 || nh[1] == 0) begin
        m_phase = 3; m_left = KT;
        m_win = (nh[1] == 0 ? 1 : 0) + (nh[0] == 0 ? 2 : 0);
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
    for (int i = 0; i < 2; i++) begin
      if (old_phase == 2 && m_phase == 2) begin
        if (m_age[i] < 0) begin
          if (ki[i] || pu[i]) begin
            m_age[i] = 0; m_kick[i] = ki[i]; m_hit[i] = 1'b0;
          end
        end else begin
          m_age[i]++;
          if (m_age[i] >= AT + CT) m_age[i] = -1;
        end
        if (m_age[i] >= 0 && m_age[i] < AT) m_pose[i] = m_kick[i] ? 2 : 1;
        else m_pose[i] = bl[i] ? 4 : 0;
      end else begin
        m_age[i] = -1; m_pose[i] = 0;
      end
    end
    m_hp = nh;
  endtask

  task automatic check_all();
    check("game_tick",   8'(game_tick),     8'(m_cnt == TD - 1));
    check("round_state", 8'(round_state),   8'(m_phase));
    check("move_enable", 8'(move_enable),   8'(m_phase == 2));
    check("health_l",    8'(health_l),      8'(m_hp[0]));
    check("health_r",    8'(health_r),      8'(m_hp[1]));
    check("winner",      8'(winner),        8'(m_win));
    check("p1_char",     8'(p1_char_state), 8'(m_pose[0]));
    check("p2_char",     8'(p2_char_state), 8'(m_pose[1]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (m_cnt == TD - 1) model_tick();
    m_cnt = (m_cnt + 1) % TD;
    check_all();
  endtask

  // Bit order: start, p1 punch/kick/block, p2 punch/kick/block, p1/p2 colliding.
  task automatic drive(input logic [8:0] fixed, input logic [8:0] mask);
    logic [8:0] r;
    r = 9'($urandom);
    {start, p1_punch, p1_kick, p1_block, p2_punch, p2_kick, p2_block,
     p1_colliding, p2_colliding} = fixed | (r & mask);
  endtask

  task automatic run(input logic [8:0] fixed, input logic [8:0] mask, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      drive(fixed, mask);
      step();
    end
  endtask

  // Entered just after a sampling point; drops reset mid-cycle, checks before any edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int budget;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b1;

    run(9'b1_110_000_10, 9'b0, 600);
    run(9'b1_010_010_11, 9'b0, 600);
    run(9'b1_001_100_01, 9'b0, 900);
    run(9'b1_100_000_10, 9'b0, 700);

    run(9'b1_010_001_10, 9'b0_000_001_00, 60);
    budget = 0;
    while (m_phase != 2 && budget < 200) begin
      drive(9'b1_010_000_10, 9'b0);
      step();
      budget++;
    end
    check("fight_reached", 8'(budget < 200), 8'd1);
    run(9'b0_010_000_10, 9'b0, 9);
    async_reset();
    run(9'b1_000_000_00, 9'b0, 20);

    for (int blk = 0; blk < 6; blk++) begin
      run(9'b0, 9'h1FF, 300 + int'($urandom_range(0, 200)));
      async_reset();
    end
    run(9'b0, 9'h1FF, 400);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/combat_round_ctrl.md
Name: combat_round_ctrl

Overview:
Game-logic controller that sequences a fighting round and owns both players' health. It sits between the player inputs and collision flags and the status bar and sprite controllers. It runs the round state machine, arbitrates each player's attack, registers at most one hit per attack, applies damage to health, and declares the winner.

Parameters:
TICK_DIV, 1666666, clk cycles per game tick (~60 Hz at 100 MHz); minimum 2.
MAX_HEALTH, 31, health loaded at round start; fits 5 bits.
PUNCH_DMG, 2, damage of an unblocked punch.
KICK_DMG, 4, damage of an unblocked kick.
ACTIVE_TICKS, 8, ticks an attack stays ACTIVE, at least 1.
COOLDOWN_TICKS, 12, ticks in COOLDOWN after ACTIVE, at least 1.
COUNTDOWN_TICKS, 180, ticks of pre-fight countdown.
KO_TICKS, 180, ticks the KO screen is held.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
start  in  1  level; begins a round when sampled high in IDLE
p1_punch, p1_kick, p1_block  in  1 each  player 1 action levels
p2_punch, p2_kick, p2_block  in  1 each  player 2 action levels
p1_colliding, p2_colliding  in  1 each  collision-detection flags; a hit lands if either is high
health_l  out  5  player 1 health
health_r  out  5  player 2 health
p1_char_state, p2_char_state  out  3  sprite pose: 000 idle, 001 punch, 010 kick, 100 block
round_state  out  2  00 IDLE, 01 COUNTDOWN, 10 FIGHT, 11 KO
winner  out  2  00 none, 01 P1, 10 P2, 11 draw
game_tick  out  1  one-cycle pulse each tick
move_enable  out  1  high only in FIGHT; gates the physics engine

Behaviour:
- Reset (async, any time, including mid-round): tick counter 0; round_state IDLE; health_l and health_r = MAX_HEALTH; winner 00; both attack FSMs READY; char_states 000; game_tick 0; move_enable 0.
- Tick counter: counts 0..TICK_DIV-1 and wraps. game_tick is high in the cycle where count==TICK_DIV-1. All FSM, timer and health updates take effect on the clk edge ending that cycle. Inputs are sampled only on that edge.
- Round FSM:
  - IDLE: on tick with start=1, reload both health values to MAX_HEALTH, clear winner, load timer=COUNTDOWN_TICKS-1, go to COUNTDOWN.
  - COUNTDOWN: decrement timer each tick; on tick with timer==0, go to FIGHT.
  - FIGHT: on the tick where either health becomes 0, go to KO with timer=KO_TICKS-1. winner = 01 if only health_r is 0, 10 if only health_l is 0, 11 if both are 0.
  - KO: decrement timer each tick; on tick with timer==0, go to IDLE. winner and health hold until the next start.
  - start is ignored outside IDLE.
- Per-player attack FSM (identical and independent for each player; only advances in FIGHT; forced to READY in any other state):
  - READY: on tick, kick=1 gives ACTIVE/kick (kick wins over punch); else punch=1 gives ACTIVE/punch. Timer=ACTIVE_TICKS-1 and hit_done is cleared. block does not stop an attack from starting.
  - ACTIVE: decrement timer each tick; on timer==0, go to COOLDOWN with timer=COOLDOWN_TICKS-1.
  - COOLDOWN: attack inputs are ignored; on timer==0, go to READY.
  - Holding a button re-triggers the attack after COOLDOWN ends (inputs are level-sensitive).
- Hit registration: on a FIGHT tick where an attacker is ACTIVE, hit_done=0 and (p1_colliding|p2_colliding)=1:
  - set hit_done; subtract damage from the opponent's health.
  - damage = PUNCH_DMG or KICK_DMG; halved (logical shift right 1) if the defender's block=1 on that tick.
  - subtraction saturates at 0 and never wraps.
  - Both players may land hits on the same tick; both subtractions apply, which can produce a draw.
  - The hit is registered on the same edge the ACTIVE timer decrements.
- char_state: 001/010 while ACTIVE; otherwise 100 if block=1 in FIGHT; else 000. Registered on tick.

Test Plan:
- Params TICK_DIV=4, COUNTDOWN_TICKS=2, ACTIVE_TICKS=2, COOLDOWN_TICKS=2, KO_TICKS=2. Assert reset, then release; pulse start -> game_tick every 4 clks; round_state 00->01 on first tick, 01->10 two ticks later; move_enable=1 in FIGHT; health_l=health_r=31.
- FIGHT, p1_kick held 1 tick, p1_colliding=1 -> health_r 31->27 exactly once across both ACTIVE ticks; p1_char_state=010 for 2 ticks, then 000.
- FIGHT, p2_punch while p1_block=1 and colliding -> health_l 31->30. p1_punch and p1_kick held together -> kick chosen, damage 4.
- Simultaneous kicks while colliding with health_l=health_r=3 -> both 0 on the same tick; round_state=11, winner=11; back to 00 after 2 ticks with health still 0.
- health_r=1, P1 kick lands -> health_r=0 (no wrap), winner=01. start held high during KO -> ignored; new round begins only from IDLE.
- reset driven low mid-FIGHT, mid-tick -> all outputs return to reset values immediately, without waiting for a clk edge.
